pcd_frame_decode: RTL and testbench

Controller that sequences the PCD->PICC bit-sequence stream produced by sequence_decode into frames. It consumes one PCDBitSequence per seq_valid and tracks SOC/data/EOC framing per ISO/IEC 14443-2 Modified Miller rules. Bits are emitted one sequence late because Y and Z are ambiguous without lookahead. The bit stream, frame delimiters and error flags go to the downstream framing/CRC logic.

---
 rtl/pcd_frame_decode_pkg.sv | 22 ++
 rtl/pcd_frame_decode_parity.sv | 42 ++++
 rtl/pcd_frame_decode.sv | 164 ++++++++++++++++
 tb/tb_pcd_frame_decode.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcd_frame_decode_pkg.sv
// Shared ISO/IEC 14443-A PCD->PICC decode types.
package ISO14443A_pkg;

  // Modified Miller bit sequences reported by sequence_decode
  typedef enum logic [1:0] {
    SEQ_X     = 2'd0,
    SEQ_Y     = 2'd1,
    SEQ_Z     = 2'd2,
    SEQ_ERROR = 2'd3
  } PCDBitSequence;

  // Frame decoder states
  typedef enum logic {
    FDS_IDLE = 1'b0,
    FDS_DATA = 1'b1
  } FrameDecodeState;

  // Eight data bits plus one odd-parity bit
  localparam int unsigned PARITY_GROUP_LEN = 9;
  localparam int unsigned PARITY_CNT_W     = 4;

endpackage

// File: rtl/pcd_frame_decode_parity.sv
// Odd-parity checker over 9-bit groups of the emitted bit stream.
module frame_parity_check
  import ISO14443A_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic emit,
  input  logic bit_in,
  output logic parity_err_c
);

  localparam logic [PARITY_CNT_W-1:0] GRP_LAST = PARITY_CNT_W'(PARITY_GROUP_LEN - 1);

  logic [PARITY_CNT_W-1:0] grp_cnt;
  logic                    acc;

  // Flag the group-closing bit when the nine bits XOR to 0 (even parity)
  always_comb begin
    parity_err_c = emit && (grp_cnt == GRP_LAST) && !(acc ^ bit_in);
  end

  // Group position and running XOR of the bits seen so far in the group
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grp_cnt <= '0;
      acc     <= 1'b0;
    end else if (clear) begin
      grp_cnt <= '0;
      acc     <= 1'b0;
    end else if (emit) begin
      if (grp_cnt == GRP_LAST) begin
        grp_cnt <= '0;
        acc     <= 1'b0;
      end else begin
        grp_cnt <= grp_cnt + PARITY_CNT_W'(1);
        acc     <= acc ^ bit_in;
      end
    end
  end

endmodule

// File: rtl/pcd_frame_decode.sv
// PCD->PICC frame decoder: turns Modified Miller sequences into SOC, data
// bits and EOC. Bits leave one sequence late since Y/Z need lookahead.
// Optional parity checking: define PCD_FRAME_DECODE_PARITY_CHECK_EN.
module pcd_frame_decode
  import ISO14443A_pkg::*;
#(
  parameter int unsigned BIT_COUNT_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  PCDBitSequence          seq,
  input  logic                   seq_valid,
  output logic                   soc,
  output logic                   eoc,
  output logic                   data_bit,
  output logic                   data_valid,
  output logic [BIT_COUNT_W-1:0] bit_count,
  output logic                   error,
  output logic                   parity_error
);

  localparam logic [BIT_COUNT_W-1:0] BC_MAX = '1;

  FrameDecodeState        state, state_nxt;
  PCDBitSequence          prev, prev_nxt;
  logic                   pend_valid, pend_valid_nxt;
  logic                   pend_val, pend_val_nxt;
  logic [BIT_COUNT_W-1:0] bit_count_nxt;
  logic                   soc_nxt, eoc_nxt, err_nxt, data_bit_nxt;
  logic                   emit_req, emit_val, emit_c;
  logic                   parity_err_c;

  // Next-state, pending-bit and output decisions for one strobe
  always_comb begin
    state_nxt      = state;
    prev_nxt       = prev;
    pend_valid_nxt = pend_valid;
    pend_val_nxt   = pend_val;
    bit_count_nxt  = bit_count;
    data_bit_nxt   = data_bit;
    soc_nxt        = 1'b0;
    eoc_nxt        = 1'b0;
    err_nxt        = 1'b0;
    emit_req       = 1'b0;
    emit_val       = pend_val;
    emit_c         = 1'b0;

    if (seq_valid) begin
      case (state)
        FDS_IDLE: begin
          case (seq)
            SEQ_Z: begin
              soc_nxt        = 1'b1;
              state_nxt      = FDS_DATA;
              prev_nxt       = SEQ_Z;
              pend_valid_nxt = 1'b0;
              pend_val_nxt   = 1'b0;
              bit_count_nxt  = '0;
            end
            SEQ_Y:   ;
            default: err_nxt = 1'b1;
          endcase
        end
        FDS_DATA: begin
          case (seq)
            SEQ_X: begin
              emit_req       = pend_valid;
              pend_valid_nxt = 1'b1;
              pend_val_nxt   = 1'b1;
              prev_nxt       = SEQ_X;
            end
            SEQ_Z: begin
              if (prev == SEQ_X) begin
                err_nxt        = 1'b1;
                state_nxt      = FDS_IDLE;
                pend_valid_nxt = 1'b0;
              end else begin
                emit_req       = pend_valid;
                pend_valid_nxt = 1'b1;
                pend_val_nxt   = 1'b0;
                prev_nxt       = SEQ_Z;
              end
            end
            SEQ_Y: begin
              if (prev == SEQ_X) begin
                emit_req       = pend_valid;
                pend_valid_nxt = 1'b1;
                pend_val_nxt   = 1'b0;
                prev_nxt       = SEQ_Y;
              end else begin
                // Pending 0 is the EOC logic-0, never a data bit
                eoc_nxt        = 1'b1;
                state_nxt      = FDS_IDLE;
                pend_valid_nxt = 1'b0;
              end
            end
            default: begin
              err_nxt        = 1'b1;
              state_nxt      = FDS_IDLE;
              pend_valid_nxt = 1'b0;
            end
          endcase
        end
        default: state_nxt = FDS_IDLE;
      endcase
    end

    // A full bit counter aborts the frame instead of emitting
    if (emit_req) begin
      if (bit_count == BC_MAX) begin
        err_nxt        = 1'b1;
        state_nxt      = FDS_IDLE;
        pend_valid_nxt = 1'b0;
      end else begin
        emit_c        = 1'b1;
        data_bit_nxt  = emit_val;
        bit_count_nxt = bit_count + BIT_COUNT_W'(1);
      end
    end
  end

`ifdef PCD_FRAME_DECODE_PARITY_CHECK_EN
  frame_parity_check u_parity (
    .clk          (clk),
    .rst          (rst),
    .clear        (soc_nxt),
    .emit         (emit_c),
    .bit_in       (emit_val),
    .parity_err_c (parity_err_c)
  );
`else
  assign parity_err_c = 1'b0;
`endif

  // State register and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= FDS_IDLE;
      prev         <= SEQ_Z;
      pend_valid   <= 1'b0;
      pend_val     <= 1'b0;
      bit_count    <= '0;
      soc          <= 1'b0;
      eoc          <= 1'b0;
      error        <= 1'b0;
      data_bit     <= 1'b0;
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
    end else begin
      state        <= state_nxt;
      prev         <= prev_nxt;
      pend_valid   <= pend_valid_nxt;
      pend_val     <= pend_val_nxt;
      bit_count    <= bit_count_nxt;
      soc          <= soc_nxt;
      eoc          <= eoc_nxt;
      error        <= err_nxt;
      data_bit     <= data_bit_nxt;
      data_valid   <= emit_c;
      parity_error <= parity_err_c;
    end
  end

endmodule

// File: tb/tb_pcd_frame_decode.sv
// Self-checking bench for pcd_frame_decode; frames are built from bit lists
// by a Modified Miller encoder and the decoded stream is compared to them.
module tb_pcd_frame_decode;
  import ISO14443A_pkg::*;

  typedef bit            bitq_t[$];
  typedef PCDBitSequence seqq_t[$];
  typedef int            intq_t[$];

  localparam int unsigned BCW    = 10;
  localparam int          BC_MAX = (1 << BCW) - 1;
`ifdef PCD_FRAME_DECODE_PARITY_CHECK_EN
  localparam bit PARITY_ON = 1'b1;
`else
  localparam bit PARITY_ON = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  PCDBitSequence  seq;
  logic           seq_valid;
  logic           soc, eoc, data_bit, data_valid, error, parity_error;
  logic [BCW-1:0] bit_count;

  int    n_checks = 0;
  int    n_fail   = 0;
  bitq_t cap_bits;
  intq_t cap_par;
  int    cap_soc, cap_eoc, cap_err, cap_stray;

  pcd_frame_decode #(.BIT_COUNT_W(BCW)) dut (
    .clk          (clk),
    .rst          (rst),
    .seq          (seq),
    .seq_valid    (seq_valid),
    .soc          (soc),
    .eoc          (eoc),
    .data_bit     (data_bit),
    .data_valid   (data_valid),
    .bit_count    (bit_count),
    .error        (error),
    .parity_error (parity_error)
  );

  always #5 clk = ~clk;

  task automatic clear_cap();
    cap_bits.delete();
    cap_par.delete();
    cap_soc = 0; cap_eoc = 0; cap_err = 0; cap_stray = 0;
  endtask

  // One clock with an optional strobe; outputs sampled 1 time unit after the edge
  task automatic step(input PCDBitSequence s, input logic v);
    seq = s; seq_valid = v;
    @(posedge clk); #1;
    seq_valid = 1'b0;
    if (data_valid) begin
      if (parity_error) cap_par.push_back(cap_bits.size());
      cap_bits.push_back(data_bit);
    end else if (parity_error) cap_stray++;
    if (soc)   cap_soc++;
    if (eoc)   cap_eoc++;
    if (error) cap_err++;
  endtask

  task automatic send(input seqq_t q, input int unsigned max_gap);
    foreach (q[i]) begin
      step(q[i], 1'b1);
      repeat ($urandom_range(max_gap, 0)) step(SEQ_Y, 1'b0);
    end
    repeat (2) step(SEQ_Y, 1'b0);
  endtask

  // Modified Miller: 1 -> X; 0 -> Y after a 1, else Z; SOC = Z; EOC = logic 0 then Y
  function automatic seqq_t encode(input bitq_t b);
    seqq_t q;
    bit    last_one = 1'b0;
    q.push_back(SEQ_Z);
    foreach (b[i]) begin
      if (b[i]) q.push_back(SEQ_X);
      else      q.push_back(last_one ? SEQ_Y : SEQ_Z);
      last_one = b[i];
    end
    q.push_back(last_one ? SEQ_Y : SEQ_Z);
    q.push_back(SEQ_Y);
    return q;
  endfunction

  // Bit positions that close a complete 9-bit group with even parity
  function automatic intq_t exp_parity(input bitq_t b);
    intq_t r;
    for (int g = 0; (g + 1) * 9 <= b.size(); g++) begin
      bit x = 1'b0;
      for (int k = 0; k < 9; k++) x ^= b[g*9 + k];
      if (!x && PARITY_ON) r.push_back(g*9 + 8);
    end
    return r;
  endfunction

  function automatic bit same_bits(input bitq_t a, input bitq_t b);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] != b[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit same_ints(input intq_t a, input intq_t b);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] != b[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bitq_t rand_bits(input int n);
    bitq_t b;
    for (int i = 0; i < n; i++) b.push_back(1'($urandom_range(1, 0)));
    return b;
  endfunction

  task automatic test_reset();
    rst = 1'b1; seq = SEQ_Y; seq_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({soc, eoc, data_valid, error, parity_error, data_bit} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 000000",
               {soc, eoc, data_valid, error, parity_error, data_bit});
    end
    n_checks++;
    if (bit_count !== '0) begin
      n_fail++; $display("FAIL reset_bit_count: got %0d required 0", bit_count);
    end
    rst = 1'b0;
    repeat (2) step(SEQ_Y, 1'b0);
  endtask

  task automatic test_directed();
    seqq_t cases[3];
    bitq_t exps[3];
    cases[0] = '{SEQ_Z, SEQ_X, SEQ_X, SEQ_Y, SEQ_Z, SEQ_Y, SEQ_Y};
    exps[0]  = '{1'b1, 1'b1, 1'b0};
    cases[1] = '{SEQ_Z, SEQ_Z, SEQ_Y};
    cases[2] = '{SEQ_Z, SEQ_Y};
    for (int i = 0; i < 3; i++) begin
      clear_cap();
      send(cases[i], 1);
      n_checks++;
      if (cap_soc != 1 || cap_eoc != 1 || cap_err != 0) begin
        n_fail++;
        $display("FAIL directed%0d_pulses: got soc=%0d eoc=%0d err=%0d required 1 1 0",
                 i, cap_soc, cap_eoc, cap_err);
      end
      n_checks++;
      if (!same_bits(cap_bits, exps[i])) begin
        n_fail++;
        $display("FAIL directed%0d_bits: got %p required %p", i, cap_bits, exps[i]);
      end
      n_checks++;
      if (int'(bit_count) != exps[i].size()) begin
        n_fail++;
        $display("FAIL directed%0d_bit_count: got %0d required %0d", i, bit_count, exps[i].size());
      end
    end
  endtask

  task automatic test_errors();
    seqq_t q;
    // Error after one emitted bit, then a fresh SOC clears the counter
    clear_cap();
    q = '{SEQ_Z, SEQ_X, SEQ_X, SEQ_ERROR};
    send(q, 1);
    n_checks++;
    if (cap_err != 1 || cap_eoc != 0 || cap_bits.size() != 1 || int'(bit_count) != 1) begin
      n_fail++;
      $display("FAIL abort_frame: got err=%0d eoc=%0d bits=%0d count=%0d required 1 0 1 1",
               cap_err, cap_eoc, cap_bits.size(), bit_count);
    end
    step(SEQ_Z, 1'b1);
    n_checks++;
    if (soc !== 1'b1 || bit_count !== '0) begin
      n_fail++;
      $display("FAIL resoc_clear: got soc=%b count=%0d required 1 0", soc, bit_count);
    end
    step(SEQ_Y, 1'b1);
    step(SEQ_Y, 1'b0);
    // X while idle
    clear_cap();
    step(SEQ_X, 1'b1);
    n_checks++;
    if (error !== 1'b1) begin
      n_fail++; $display("FAIL idle_x_error: got %b required 1", error);
    end
    step(SEQ_Y, 1'b0);
    n_checks++;
    if (error !== 1'b0) begin
      n_fail++; $display("FAIL error_one_cycle: got %b required 0", error);
    end
    step(SEQ_Y, 1'b1);
    step(SEQ_Y, 1'b0);
    n_checks++;
    if (cap_soc != 0 || cap_eoc != 0 || cap_err != 1) begin
      n_fail++;
      $display("FAIL idle_ignore: got soc=%0d eoc=%0d err=%0d required 0 0 1", cap_soc, cap_eoc, cap_err);
    end
    // X followed by Z inside a frame
    clear_cap();
    q = '{SEQ_Z, SEQ_X, SEQ_Z, SEQ_Y};
    send(q, 0);
    n_checks++;
    if (cap_err != 1 || cap_eoc != 0 || cap_bits.size() != 0) begin
      n_fail++;
      $display("FAIL x_then_z: got err=%0d eoc=%0d bits=%0d required 1 0 0",
               cap_err, cap_eoc, cap_bits.size());
    end
  endtask

  task automatic test_random_frames(input int unsigned n_frames, input int unsigned max_gap);
    for (int f = 0; f < int'(n_frames); f++) begin
      bitq_t b;
      intq_t pe;
      if (f == 0 && max_gap != 0) b = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      else b = rand_bits(int'($urandom_range(40, 0)));
      pe = exp_parity(b);
      clear_cap();
      send(encode(b), max_gap);
      n_checks++;
      if (cap_soc != 1 || cap_eoc != 1 || cap_err != 0) begin
        n_fail++;
        $display("FAIL frame%0d_gap%0d_pulses: got soc=%0d eoc=%0d err=%0d required 1 1 0",
                 f, max_gap, cap_soc, cap_eoc, cap_err);
      end
      n_checks++;
      if (!same_bits(cap_bits, b)) begin
        n_fail++;
        $display("FAIL frame%0d_gap%0d_bits: got %p required %p", f, max_gap, cap_bits, b);
      end
      n_checks++;
      if (int'(bit_count) != b.size()) begin
        n_fail++;
        $display("FAIL frame%0d_gap%0d_count: got %0d required %0d", f, max_gap, bit_count, b.size());
      end
      n_checks++;
      if (!same_ints(cap_par, pe) || cap_stray != 0) begin
        n_fail++;
        $display("FAIL frame%0d_gap%0d_parity: got %p stray=%0d required %p stray=0",
                 f, max_gap, cap_par, cap_stray, pe);
      end
    end
  endtask

  task automatic test_parity();
    for (int p = 0; p < 2; p++) begin
      bitq_t b;
      intq_t pe;
      logic [7:0] v = 8'h93;
      for (int i = 0; i < 8; i++) b.push_back(v[i]);
      b.push_back(1'(p));
      if (PARITY_ON && p == 0) pe.push_back(8);
      clear_cap();
      send(encode(b), 1);
      n_checks++;
      if (!same_ints(cap_par, pe) || cap_stray != 0) begin
        n_fail++;
        $display("FAIL parity_0x93_p%0d: got %p stray=%0d required %p stray=0",
                 p, cap_par, cap_stray, pe);
      end
      n_checks++;
      if (!same_bits(cap_bits, b) || cap_eoc != 1) begin
        n_fail++;
        $display("FAIL parity_0x93_p%0d_bits: got %p eoc=%0d required %p eoc=1",
                 p, cap_bits, cap_eoc, b);
      end
    end
  endtask

  task automatic test_saturation();
    clear_cap();
    step(SEQ_Z, 1'b1);
    repeat (BC_MAX + 1) step(SEQ_X, 1'b1);
    n_checks++;
    if (int'(bit_count) != BC_MAX || cap_bits.size() != BC_MAX || cap_err != 0) begin
      n_fail++;
      $display("FAIL sat_reach: got count=%0d bits=%0d err=%0d required %0d %0d 0",
               bit_count, cap_bits.size(), cap_err, BC_MAX, BC_MAX);
    end
    step(SEQ_X, 1'b1);
    step(SEQ_Y, 1'b1);
    step(SEQ_Y, 1'b0);
    n_checks++;
    if (cap_err != 1 || cap_eoc != 0 || int'(bit_count) != BC_MAX || cap_bits.size() != BC_MAX) begin
      n_fail++;
      $display("FAIL sat_abort: got err=%0d eoc=%0d count=%0d bits=%0d required 1 0 %0d %0d",
               cap_err, cap_eoc, bit_count, cap_bits.size(), BC_MAX, BC_MAX);
    end
    step(SEQ_Z, 1'b1);
    n_checks++;
    if (soc !== 1'b1 || bit_count !== '0) begin
      n_fail++; $display("FAIL sat_resoc: got soc=%b count=%0d required 1 0", soc, bit_count);
    end
    step(SEQ_Y, 1'b1);
    step(SEQ_Y, 1'b0);
  endtask

  task automatic test_reset_midframe();
    seqq_t q;
    clear_cap();
    q = '{SEQ_Z, SEQ_X, SEQ_X, SEQ_X, SEQ_X};
    foreach (q[i]) step(q[i], 1'b1);
    n_checks++;
    if (cap_bits.size() != 3 || int'(bit_count) != 3) begin
      n_fail++;
      $display("FAIL midrst_pre: got bits=%0d count=%0d required 3 3", cap_bits.size(), bit_count);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({soc, eoc, data_valid, error, parity_error, data_bit} !== 6'b0 || bit_count !== '0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got %b count=%0d required 000000 0",
               {soc, eoc, data_valid, error, parity_error, data_bit}, bit_count);
    end
    seq = SEQ_Z; seq_valid = 1'b1;
    @(posedge clk); #1;
    seq_valid = 1'b0;
    n_checks++;
    if (soc !== 1'b0 || error !== 1'b0) begin
      n_fail++; $display("FAIL strobe_in_reset: got soc=%b err=%b required 0 0", soc, error);
    end
    rst = 1'b0;
    clear_cap();
    step(SEQ_Y, 1'b1);
    step(SEQ_Y, 1'b0);
    n_checks++;
    if (cap_eoc != 0 || cap_err != 0 || cap_soc != 0) begin
      n_fail++;
      $display("FAIL midrst_idle: got soc=%0d eoc=%0d err=%0d required 0 0 0", cap_soc, cap_eoc, cap_err);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_errors();
    test_random_frames(20, 2);
    test_random_frames(6, 0);
    test_parity();
    test_saturation();
    test_reset_midframe();
    test_random_frames(4, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
